ahfp_floor_arbiter: RTL and testbench
=====================================

Name: ahfp_floor_arbiter

Overview:
- Shares one combinational single-precision floor unit between NUM_REQ requesters.
- Round-robin arbitration, valid/ready handshakes on both sides, 2-stage registered pipeline (operand register -> floor -> result register).
- Returns each result tagged with the requester index, so the downstream FP scheduler can route it back.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of rsp_id; must satisfy 2^ID_W >= NUM_REQ

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_data  in  32*NUM_REQ  IEEE-754 operand; requester i occupies bits [32*i+31:32*i]
- req_ready  out  NUM_REQ  one-hot grant/accept; at most one bit set
- rsp_valid  out  1  result valid
- rsp_data  out  32  floor result
- rsp_id  out  ID_W  index of the originating requester
- rsp_ready  in  1  downstream accepts result

Behaviour:
- Reset: all state clears asynchronously on rst_n low.
  - rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0.
  - Stage-1 valid=0; round-robin pointer=0.
- Stage 1 (S1) holds s1_valid, s1_data, s1_id. Stage 2 (S2) is the output register.
- The floor sub-module sees s1_data combinationally. Its result is captured into S2 together with s1_id.
- Advance conditions:
  - s2_adv = s1_valid && (!rsp_valid || rsp_ready).
  - s1_free = !s1_valid || s2_adv.
- Arbitration:
  - When s1_free, the grant goes to the first asserted req_valid searching from the pointer upward, with wrap-around modulo NUM_REQ.
  - req_ready[g]=1 only for that requester, and only while s1_free. req_ready is combinational from req_valid, s1_free and the pointer.
- Transfer: a request transfers when req_valid[g] && req_ready[g]. On transfer:
  - S1 loads req_data[g] and id g.
  - Pointer becomes (g+1) mod NUM_REQ.
  - With no transfer, the pointer holds.
- S1 with no new transfer: if s2_adv && no transfer, s1_valid clears.
- S2:
  - On s2_adv: rsp_valid=1, and rsp_data/rsp_id load from the floor result and s1_id.
  - Else if rsp_ready, rsp_valid clears.
  - rsp_data and rsp_id stay stable while rsp_valid && !rsp_ready.
- Throughput and latency:
  - 1 op/cycle sustained when rsp_ready is held high.
  - Latency is 2 cycles from req handshake to rsp_valid.
- Backpressure: with rsp_ready low, S2 holds and S1 fills; req_ready then deasserts. Nothing is ever dropped or overwritten.
- Simultaneous drain and fill: S2 drain, S1->S2 and a new S1 load may all occur in the same cycle.
- Floor semantics are those of the shared floor unit:
  - exponent < 127 gives 0x00000000.
  - A negative input gives the sign bit only (0x80000000).
  - exponent >= 150 passes the operand unchanged.
- Reset mid-operation discards in-flight operands. No response is generated for them.

Optional Feature:
- Macro: AHFP_FLOOR_ARB_PERF_EN.
- When defined, adds output ports perf_ops (32-bit) and perf_stall (32-bit), both reset to 0 and wrapping at 2^32.
  - perf_ops increments on each rsp handshake.
  - perf_stall increments in each cycle where rsp_valid && !rsp_ready.
- When undefined, these ports and counters do not exist and the rest of the behaviour is identical.

Decomposition:
- Shared package ahfp_pkg:
  - FP_W=32, EXP_BIAS=8'd127, MANT_W=23.
  - Constants FP_POS_ZERO=32'h00000000 and FP_NEG_ZERO=32'h80000000, for bench use.
- Sub-module: rr_arbiter (NUM_REQ). Inputs: req vector, pointer, enable. Outputs: one-hot grant and encoded index.
- The existing floor module is instantiated unmodified as the datapath.

Test Plan:
- Req0 only, req_data=0x40490FDB (3.14159), rsp_ready=1 -> rsp_valid 2 cycles later with rsp_data=0x40400000, rsp_id=0.
- Req1=0xBF800000 (-1.0), Req2=0x3F000000 (0.5), both valid in the same cycle from reset -> req1 is granted first (pointer 0 searches up to 1).
  - Responses: 0x80000000 id1, then 0x00000000 id2 on consecutive cycles.
- All 4 requesters held valid for 8 cycles, rsp_ready=1 -> grants cycle 0,1,2,3,0,1,2,3 and 8 responses in order, no gaps.
- rsp_ready=0 for 5 cycles with all requesters valid -> exactly 2 accepts, then req_ready=0.
  - rsp_data stays stable.
  - Raising rsp_ready drains both results in order.
- Operand 0x4B000001 (exponent 150) -> 0x4B000001 unchanged. Operand 0x3F7FFFFF (~0.99999994) -> 0x00000000.
- rst_n pulsed low while S1 and S2 are full -> rsp_valid=0 immediately (asynchronous), and the pointer restarts at 0.

Source files
------------

// File: rtl/ahfp_pkg.sv
// -----------------------------------------------------------------------------
// ahfp_pkg
// Shared single-precision constants and field layout for the floor arbiter
// slice.
// Contents: FP_W, EXP_BIAS, MANT_W, the signed-zero constants, fp32_t.
// -----------------------------------------------------------------------------
package ahfp_pkg;

    localparam int unsigned FP_W   = 32;
    localparam int unsigned MANT_W = 23;
    localparam logic [7:0]  EXP_BIAS = 8'd127;

    // Smallest biased exponent at which every mantissa bit is integral.
    localparam logic [7:0]  EXP_INT = EXP_BIAS + 8'(MANT_W);

    localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;
    localparam logic [FP_W-1:0] FP_NEG_ZERO = 32'h8000_0000;

    typedef struct packed {
        logic                sign;
        logic [7:0]          exp;
        logic [MANT_W-1:0]   mant;
    } fp32_t;

endpackage

// File: rtl/ahfp_floor.sv
// -----------------------------------------------------------------------------
// ahfp_floor
// Combinational single-precision floor unit shared by the arbiter.
// Ports:
//   a  in  32  IEEE-754 operand
//   y  out 32  floor result
// Semantics: negative -> 0x80000000, exponent < 127 -> 0x00000000,
// exponent >= 150 -> operand unchanged, otherwise fraction bits cleared.
// -----------------------------------------------------------------------------
module ahfp_floor
    import ahfp_pkg::*;
(
    input  logic [FP_W-1:0] a,
    output logic [FP_W-1:0] y
);

    fp32_t             x;
    logic [7:0]        frac_bits;
    logic [MANT_W-1:0] mask;
    logic [MANT_W-1:0] mask_all;

    always_comb begin
        x         = a;
        mask_all  = '1;
        frac_bits = EXP_INT - x.exp;
        // Only meaningful when 127 <= exp < 150, i.e. frac_bits in 1..23.
        mask      = mask_all << frac_bits[4:0];
        y         = a;
        if (x.sign) begin
            y = FP_NEG_ZERO;
        end else if (x.exp < EXP_BIAS) begin
            y = FP_POS_ZERO;
        end else if (x.exp >= EXP_INT) begin
            y = a;
        end else begin
            y = {x.sign, x.exp, x.mant & mask};
        end
    end

endmodule

// File: rtl/ahfp_floor_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter: first asserted request at or above ptr,
// wrapping modulo NUM_REQ.
// Ports:
//   req    in  NUM_REQ  request vector
//   ptr    in  ID_W     search start index
//   en     in  1        grant enable
//   grant  out NUM_REQ  one-hot grant (zero when disabled or idle)
//   idx    out ID_W     encoded index of the grant
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    int unsigned k;
    logic        found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            k = (32'(ptr) + off) % NUM_REQ;
            if (en && !found && req[k]) begin
                grant[k] = 1'b1;
                idx      = ID_W'(k);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahfp_floor_arbiter.sv
// -----------------------------------------------------------------------------
// ahfp_floor_arbiter
// Shares one floor unit between NUM_REQ requesters: round-robin grant,
// operand register (S1) -> floor -> result register (S2), results tagged
// with the requester index.
// Ports:
//   clk        in  1            clock, rising edge
//   rst_n      in  1            asynchronous active-low reset
//   req_valid  in  NUM_REQ      per-requester valid
//   req_data   in  32*NUM_REQ   operands, requester i at [32*i+31:32*i]
//   req_ready  out NUM_REQ      one-hot accept
//   rsp_valid  out 1            result valid
//   rsp_data   out 32           floor result
//   rsp_id     out ID_W         originating requester
//   rsp_ready  in  1            downstream accept
//   perf_ops   out 32           (AHFP_FLOOR_ARB_PERF_EN) rsp handshakes
//   perf_stall out 32           (AHFP_FLOOR_ARB_PERF_EN) stalled rsp cycles
// Optional feature macro: AHFP_FLOOR_ARB_PERF_EN
// -----------------------------------------------------------------------------
module ahfp_floor_arbiter
    import ahfp_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [FP_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rsp_valid,
    output logic [FP_W-1:0]         rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    input  logic                    rsp_ready
`ifdef AHFP_FLOOR_ARB_PERF_EN
    ,
    output logic [31:0]             perf_ops,
    output logic [31:0]             perf_stall
`endif
);

    logic               s1_valid;
    logic [FP_W-1:0]    s1_data;
    logic [ID_W-1:0]    s1_id;
    logic [ID_W-1:0]    ptr;

    logic               s2_adv;
    logic               s1_free;
    logic               xfer;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W-1:0]    ptr_next;
    logic [FP_W-1:0]    gnt_data;
    logic [FP_W-1:0]    floor_res;

    assign s2_adv  = s1_valid && (!rsp_valid || rsp_ready);
    assign s1_free = !s1_valid || s2_adv;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .en    (s1_free),
        .grant (gnt),
        .idx   (gnt_idx)
    );

    ahfp_floor u_floor (
        .a (s1_data),
        .y (floor_res)
    );

    // A grant is only issued to an asserted request, so any grant is a transfer.
    assign req_ready = gnt;
    assign xfer      = |gnt;

    always_comb begin
        gnt_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                gnt_data = req_data[i*FP_W +: FP_W];
            end
        end
    end

    always_comb begin
        if (32'(gnt_idx) == NUM_REQ - 1) begin
            ptr_next = '0;
        end else begin
            ptr_next = gnt_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_id    <= '0;
            ptr      <= '0;
        end else begin
            if (xfer) begin
                s1_valid <= 1'b1;
                s1_data  <= gnt_data;
                s1_id    <= gnt_idx;
                ptr      <= ptr_next;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            if (s2_adv) begin
                rsp_valid <= 1'b1;
                rsp_data  <= floor_res;
                rsp_id    <= s1_id;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef AHFP_FLOOR_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                perf_ops <= perf_ops + 32'd1;
            end
            if (rsp_valid && !rsp_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ahfp_floor_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ahfp_floor_arbiter
// Directed bench for ahfp_floor_arbiter (default build, perf counters absent).
// -----------------------------------------------------------------------------
module tb_ahfp_floor_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 rsp_valid;
    logic [31:0]          rsp_data;
    logic [ID_W-1:0]      rsp_id;
    logic                 rsp_ready;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ahfp_floor_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready)
    );

    typedef struct {
        logic [31:0] op;
        logic [31:0] res;
    } vec_t;

    vec_t        vecs [11];
    logic [31:0] rr_op  [4];
    logic [31:0] rr_res [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns well before the next one.
    task automatic reset_dut();
        req_valid = '0;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    logic [NUM_REQ-1:0] oh;
    int                 accepts;

    initial begin
        vecs[0]  = '{32'h40490FDB, 32'h40400000};
        vecs[1]  = '{32'hBF800000, 32'h80000000};
        vecs[2]  = '{32'h3F000000, 32'h00000000};
        vecs[3]  = '{32'h4B000001, 32'h4B000001};
        vecs[4]  = '{32'h3F7FFFFF, 32'h00000000};
        vecs[5]  = '{32'h3F800000, 32'h3F800000};
        vecs[6]  = '{32'h3FC00000, 32'h3F800000};
        vecs[7]  = '{32'h40B80000, 32'h40A00000};
        vecs[8]  = '{32'h4AFFFFFF, 32'h4AFFFFFE};
        vecs[9]  = '{32'h7F800000, 32'h7F800000};
        vecs[10] = '{32'h00000000, 32'h00000000};

        rr_op[0] = 32'h3FC00000; rr_res[0] = 32'h3F800000;
        rr_op[1] = 32'h40200000; rr_res[1] = 32'h40000000;
        rr_op[2] = 32'h40600000; rr_res[2] = 32'h40400000;
        rr_op[3] = 32'h40900000; rr_res[3] = 32'h40800000;

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_data",  rsp_data,  0);
        check("reset rsp_id",    rsp_id,    0);
        check("reset req_ready", req_ready, 0);
        rst_n = 1'b1;

        // Two simultaneous requests from reset: pointer 0 finds req1 first.
        req_data[32*1 +: 32] = 32'hBF800000;
        req_data[32*2 +: 32] = 32'h3F000000;
        req_valid = 4'b0110;
        #1;
        check("pair grant1", req_ready, 4'b0010);
        tick();
        req_valid = 4'b0100;
        #1;
        check("pair grant2", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        check("pair rsp1 valid", rsp_valid, 1);
        check("pair rsp1 data",  rsp_data,  32'h80000000);
        check("pair rsp1 id",    rsp_id,    1);
        tick();
        check("pair rsp2 valid", rsp_valid, 1);
        check("pair rsp2 data",  rsp_data,  32'h00000000);
        check("pair rsp2 id",    rsp_id,    2);
        tick();
        check("pair drained", rsp_valid, 0);

        // Table of floor vectors, each through a single requester.
        for (int i = 0; i < 11; i++) begin
            int k;
            k = i % NUM_REQ;
            oh = 4'b0001 << k;
            req_data[32*k +: 32] = vecs[i].op;
            req_valid = oh;
            #1;
            check($sformatf("vec%0d ready", i), req_ready, oh);
            tick();
            req_valid = '0;
            tick();
            check($sformatf("vec%0d valid", i), rsp_valid, 1);
            check($sformatf("vec%0d data", i),  rsp_data,  vecs[i].res);
            check($sformatf("vec%0d id", i),    rsp_id,    k);
            tick();
            check($sformatf("vec%0d drain", i), rsp_valid, 0);
        end

        // All requesters valid, sustained throughput with rotating grants.
        reset_dut();
        for (int i = 0; i < NUM_REQ; i++) req_data[32*i +: 32] = rr_op[i];
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int c = 0; c < 9; c++) begin
            if (c == 8) req_valid = '0;
            #1;
            if (c < 8) check($sformatf("rr grant c%0d", c), req_ready, 4'b0001 << (c % 4));
            tick();
            if (c >= 1) begin
                check($sformatf("rr valid c%0d", c), rsp_valid, 1);
                check($sformatf("rr id c%0d", c),    rsp_id,    (c - 1) % 4);
                check($sformatf("rr data c%0d", c),  rsp_data,  rr_res[(c - 1) % 4]);
            end
        end
        tick();
        check("rr drained", rsp_valid, 0);

        // Backpressure: two accepts fill S1/S2, then req_ready drops.
        reset_dut();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        accepts = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if ((req_valid & req_ready) != 0) accepts++;
            if (c == 0) check("bp grant0", req_ready, 4'b0001);
            if (c == 1) check("bp grant1", req_ready, 4'b0010);
            if (c >= 2) begin
                check($sformatf("bp ready c%0d", c), req_ready, 0);
                check($sformatf("bp valid c%0d", c), rsp_valid, 1);
                check($sformatf("bp data c%0d", c),  rsp_data,  rr_res[0]);
                check($sformatf("bp id c%0d", c),    rsp_id,    0);
            end
            tick();
        end
        check("bp accepts", accepts, 2);
        rsp_ready = 1'b1;
        req_valid = '0;
        #1;
        check("bp drain0 data", rsp_data, rr_res[0]);
        tick();
        check("bp drain1 valid", rsp_valid, 1);
        check("bp drain1 data",  rsp_data,  rr_res[1]);
        check("bp drain1 id",    rsp_id,    1);
        tick();
        check("bp drained", rsp_valid, 0);

        // Asynchronous reset with S1 and S2 both occupied.
        reset_dut();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        tick();
        tick();
        check("mid full", rsp_valid, 1);
        #2;
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        check("mid async valid", rsp_valid, 0);
        check("mid async data",  rsp_data,  0);
        check("mid async ready", req_ready, 0);
        #1;
        rst_n = 1'b1;
        req_valid = 4'b1111;
        #1;
        check("mid ptr restart", req_ready, 4'b0001);
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        check("mid no rsp1", rsp_valid, 0);
        tick();
        check("mid no rsp2", rsp_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
